// File: rtl/vc_flit_tx.sv
// vc_flit_tx: turns a packet descriptor plus a payload word stream into a
// header/body/tail flit sequence for a downstream virtual-channel buffer.
// A single holding register feeds the buffer; it can transfer and reload in
// the same cycle, so flits stream at one per cycle while the buffer is ready.
module vc_flit_tx #(
    parameter int FLIT_DATA_W = 8,
    parameter int FLIT_ID_W   = 2,
    parameter int LEN_W       = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             pkt_vld_i,
    output logic                             pkt_rdy_o,
    input  logic [FLIT_DATA_W-1:0]           dest_i,
    input  logic [LEN_W-1:0]                 pkt_len_i,
    input  logic                             pay_vld_i,
    output logic                             pay_rdy_o,
    input  logic [FLIT_DATA_W-1:0]           pay_data_i,
    output logic [FLIT_DATA_W+FLIT_ID_W-1:0] data_o,
    output logic                             wr_en_o,
    input  logic                             rdy_i,
    output logic                             busy_o,
    output logic                             err_o
);

    localparam int FLIT_W = FLIT_DATA_W + FLIT_ID_W;

    localparam logic [FLIT_ID_W-1:0] ID_HEADER = FLIT_ID_W'(1);
    localparam logic [FLIT_ID_W-1:0] ID_BODY   = FLIT_ID_W'(2);
    localparam logic [FLIT_ID_W-1:0] ID_TAIL   = FLIT_ID_W'(3);

    typedef enum logic {
        S_IDLE,
        S_PAY
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_out_vld;
    logic [FLIT_W-1:0]      r_out_flit;
    logic [LEN_W-1:0]       r_cnt;
    logic                   r_err;

    logic                   w_wr_en;
    logic                   w_slot_free;
    logic                   w_pkt_rdy;
    logic                   w_pay_rdy;
    logic                   w_load_hdr;
    logic                   w_load_pay;
    logic                   w_err_nxt;
    logic                   w_last;

    // The holding register empties on a transfer, which frees it for a
    // reload in the same cycle.
    assign w_wr_en     = r_out_vld && rdy_i;
    assign w_slot_free = !r_out_vld || w_wr_en;
    assign w_last      = (r_cnt == LEN_W'(1));

    assign data_o    = r_out_flit;
    assign wr_en_o   = w_wr_en;
    assign pkt_rdy_o = w_pkt_rdy;
    assign pay_rdy_o = w_pay_rdy;
    assign busy_o    = (r_state == S_PAY) || r_out_vld;
    assign err_o     = r_err;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake decode; the ready terms are gated on a free slot.
    always_comb begin
        w_state_nxt = r_state;
        w_pkt_rdy   = 1'b0;
        w_pay_rdy   = 1'b0;
        w_load_hdr  = 1'b0;
        w_load_pay  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_pkt_rdy = w_slot_free && !rst_i;
                if (pkt_vld_i && w_pkt_rdy) begin
                    if (pkt_len_i != '0) begin
                        w_load_hdr  = 1'b1;
                        w_state_nxt = S_PAY;
                    end else begin
                        // Zero-length descriptors are consumed but produce no flits.
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_PAY: begin
                w_pay_rdy = w_slot_free;
                if (pay_vld_i && w_pay_rdy) begin
                    w_load_pay = 1'b1;
                    if (w_last) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Holding register and remaining-payload counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_out_vld  <= 1'b0;
            r_out_flit <= '0;
            r_cnt      <= '0;
        end else if (w_load_hdr) begin
            r_out_vld  <= 1'b1;
            r_out_flit <= {ID_HEADER, dest_i};
            r_cnt      <= pkt_len_i;
        end else if (w_load_pay) begin
            r_out_vld  <= 1'b1;
            r_out_flit <= {(w_last ? ID_TAIL : ID_BODY), pay_data_i};
            r_cnt      <= r_cnt - LEN_W'(1);
        end else if (w_wr_en) begin
            r_out_vld  <= 1'b0;
        end
    end

    // Error pulse, one cycle after a zero-length descriptor is accepted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_nxt;
        end
    end

endmodule

// File: tb/tb_vc_flit_tx.sv
// Bench for vc_flit_tx: directed packets with literal expectations plus a
// queue-based model of the flit stream checked on every transfer.
module tb_vc_flit_tx;

    localparam int DW = 8;
    localparam int IW = 2;
    localparam int LW = 4;
    localparam int FW = DW + IW;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          pkt_vld_i;
    logic          pkt_rdy_o;
    logic [DW-1:0] dest_i;
    logic [LW-1:0] pkt_len_i;
    logic          pay_vld_i;
    logic          pay_rdy_o;
    logic [DW-1:0] pay_data_i;
    logic [FW-1:0] data_o;
    logic          wr_en_o;
    logic          rdy_i;
    logic          busy_o;
    logic          err_o;

    vc_flit_tx #(.FLIT_DATA_W(DW), .FLIT_ID_W(IW), .LEN_W(LW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .pkt_vld_i(pkt_vld_i), .pkt_rdy_o(pkt_rdy_o),
        .dest_i(dest_i), .pkt_len_i(pkt_len_i),
        .pay_vld_i(pay_vld_i), .pay_rdy_o(pay_rdy_o), .pay_data_i(pay_data_i),
        .data_o(data_o), .wr_en_o(wr_en_o), .rdy_i(rdy_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: expected flit stream, stimulus queues, transfer log.
    logic [FW-1:0]    exp_q[$];
    logic [DW+LW-1:0] desc_q[$];
    logic [DW-1:0]    pay_q[$];
    logic [FW-1:0]    xfer_dat[$];
    int               xfer_cyc[$];
    logic             err_exp = 1'b0;
    logic             pkt_hs = 1'b0;
    logic             pay_hs = 1'b0;
    logic             rand_rdy = 1'b0;
    logic             rand_vld = 1'b0;
    logic             rdy_force = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // A packet is a header carrying dest, then len payload flits of which the
    // last is a tail and the others are bodies.
    task automatic queue_pkt(input logic [DW-1:0] dest, input int len, input logic [DW-1:0] w0,
                             input logic [DW-1:0] w1, input logic [DW-1:0] w2, input logic rnd);
        logic [DW-1:0] w;
        desc_q.push_back({dest, LW'(len)});
        if (len == 0) return;
        exp_q.push_back({2'd1, dest});
        for (int i = 0; i < len; i++) begin
            if (rnd) w = DW'($urandom_range(0, 255));
            else if (i == 0) w = w0;
            else if (i == 1) w = w1;
            else w = w2;
            pay_q.push_back(w);
            exp_q.push_back({(i == len - 1) ? 2'd3 : 2'd2, w});
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_xfers(input int target, input string nm);
        int t = 0;
        while (xfer_dat.size() < target && t < 2000) begin
            step();
            t++;
        end
        if (xfer_dat.size() < target) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d transfers expected %0d", nm, xfer_dat.size(), target);
        end
    endtask

    task automatic wait_drain(input string nm);
        int t = 0;
        while ((exp_q.size() != 0 || desc_q.size() != 0 || pay_q.size() != 0 || busy_o) && t < 3000) begin
            step();
            t++;
        end
        chk({nm, "_drained"}, exp_q.size(), 0);
    endtask

    // Compare process: every transfer against the model, the error pulse
    // against the previous cycle's accept, and no write while stalled.
    always @(negedge clk) begin
        if (rst_i) begin
            err_exp = 1'b0;
            pkt_hs  = 1'b0;
            pay_hs  = 1'b0;
        end else begin
            if (!rdy_i) chk("no_write_while_stalled", wr_en_o, 0);
            chk("err_pulse", err_o, err_exp);
            err_exp = pkt_vld_i && pkt_rdy_o && (pkt_len_i == '0);
            pkt_hs  = pkt_vld_i && pkt_rdy_o;
            pay_hs  = pay_vld_i && pay_rdy_o;
            if (wr_en_o === 1'b1) begin
                xfer_dat.push_back(data_o);
                xfer_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_flit", data_o, 0);
                end else begin
                    chk("flit_stream", data_o, exp_q.pop_front());
                end
            end
        end
    end

    // Stimulus driver: retire accepted items after each edge, then present the next.
    initial begin : drv
        pkt_vld_i  = 1'b0;
        dest_i     = '0;
        pkt_len_i  = '0;
        pay_vld_i  = 1'b0;
        pay_data_i = '0;
        rdy_i      = 1'b0;
        forever begin
            @(posedge clk);
            if (pkt_hs && desc_q.size() > 0) desc_q.delete(0);
            if (pay_hs && pay_q.size() > 0) pay_q.delete(0);
            #1;
            if (desc_q.size() > 0 && (!rand_vld || $urandom_range(0, 3) != 0)) begin
                pkt_vld_i = 1'b1;
                {dest_i, pkt_len_i} = desc_q[0];
            end else begin
                pkt_vld_i = 1'b0;
            end
            if (pay_q.size() > 0 && (!rand_vld || $urandom_range(0, 2) != 0)) begin
                pay_vld_i  = 1'b1;
                pay_data_i = pay_q[0];
            end else begin
                pay_vld_i = 1'b0;
            end
            rdy_i = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
        end
    end

    initial begin : main
        int mark;
        int errs;
        rst_i = 1'b1;
        step();
        step();
        // Reset state.
        chk("rst_data", data_o, 0);
        chk("rst_wr_en", wr_en_o, 0);
        chk("rst_pkt_rdy", pkt_rdy_o, 0);
        chk("rst_pay_rdy", pay_rdy_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        rst_i     = 1'b0;
        rdy_force = 1'b1;
        step();
        step();
        chk("idle_pkt_rdy", pkt_rdy_o, 1);

        // Basic packet: four back-to-back flits, busy drops afterwards.
        mark = xfer_dat.size();
        queue_pkt(8'h5A, 3, 8'h11, 8'h22, 8'h33, 1'b0);
        wait_xfers(mark + 4, "basic");
        chk("basic_busy_at_tail", busy_o, 1);
        step();
        chk("basic_busy_fall", busy_o, 0);
        if (xfer_dat.size() >= mark + 4) begin
            chk("basic_f0", xfer_dat[mark], 10'h15A);
            chk("basic_f1", xfer_dat[mark + 1], 10'h211);
            chk("basic_f2", xfer_dat[mark + 2], 10'h222);
            chk("basic_f3", xfer_dat[mark + 3], 10'h333);
            chk("basic_consecutive", xfer_cyc[mark + 3] - xfer_cyc[mark], 3);
        end
        wait_drain("basic");

        // Backpressure: stall three cycles while the first body flit is held.
        mark = xfer_dat.size();
        queue_pkt(8'h5A, 3, 8'h11, 8'h22, 8'h33, 1'b0);
        wait_xfers(mark + 1, "bp_hdr");
        rdy_force = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_wr_en", wr_en_o, 0);
            chk("bp_hold", data_o, 10'h211);
            chk("bp_pay_rdy", pay_rdy_o, 0);
            chk("bp_pkt_rdy", pkt_rdy_o, 0);
        end
        rdy_force = 1'b1;
        wait_xfers(mark + 4, "bp");
        if (xfer_dat.size() >= mark + 4) begin
            chk("bp_f1", xfer_dat[mark + 1], 10'h211);
            chk("bp_f3", xfer_dat[mark + 3], 10'h333);
        end
        wait_drain("bp");
        chk("bp_count", xfer_dat.size() - mark, 4);

        // Single payload flit: header then tail, no body.
        mark = xfer_dat.size();
        queue_pkt(8'h07, 1, 8'hAB, 8'h00, 8'h00, 1'b0);
        wait_drain("single");
        chk("single_count", xfer_dat.size() - mark, 2);
        if (xfer_dat.size() >= mark + 2) begin
            chk("single_hdr", xfer_dat[mark], 10'h107);
            chk("single_tail", xfer_dat[mark + 1], 10'h3AB);
        end

        // Zero length: consumed, one error pulse, no flits.
        mark = xfer_dat.size();
        errs = 0;
        queue_pkt(8'h33, 0, 8'h00, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step();
            if (err_o) errs++;
        end
        chk("zero_err_cycles", errs, 1);
        chk("zero_no_flits", xfer_dat.size() - mark, 0);
        chk("zero_desc_taken", desc_q.size(), 0);
        queue_pkt(8'h01, 2, 8'hC1, 8'hC2, 8'h00, 1'b0);
        wait_drain("after_zero");
        chk("after_zero_count", xfer_dat.size() - mark, 3);
        if (xfer_dat.size() >= mark + 3) chk("after_zero_tail", xfer_dat[mark + 2], 10'h3C2);

        // Back-to-back packets: six flits on six consecutive cycles.
        mark = xfer_dat.size();
        queue_pkt(8'hA1, 2, 8'h01, 8'h02, 8'h00, 1'b0);
        queue_pkt(8'hA2, 2, 8'h03, 8'h04, 8'h00, 1'b0);
        wait_drain("b2b");
        chk("b2b_count", xfer_dat.size() - mark, 6);
        if (xfer_dat.size() >= mark + 6) begin
            chk("b2b_span", xfer_cyc[mark + 5] - xfer_cyc[mark], 5);
            chk("b2b_tail1", xfer_dat[mark + 2], 10'h302);
            chk("b2b_hdr2", xfer_dat[mark + 3], 10'h1A2);
        end

        // Reset mid-packet after header and one body flit.
        mark = xfer_dat.size();
        desc_q.push_back({8'h3C, 4'd3});
        pay_q.push_back(8'h44);
        exp_q.push_back(10'h13C);
        exp_q.push_back(10'h244);
        wait_xfers(mark + 2, "midrst");
        rst_i = 1'b1;
        #1;
        chk("midrst_data", data_o, 0);
        chk("midrst_wr_en", wr_en_o, 0);
        chk("midrst_pkt_rdy", pkt_rdy_o, 0);
        chk("midrst_pay_rdy", pay_rdy_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_err", err_o, 0);
        step();
        rst_i = 1'b0;
        step();
        chk("midrst_rel_pkt_rdy", pkt_rdy_o, 1);
        chk("midrst_rel_busy", busy_o, 0);
        for (int i = 0; i < 5; i++) step();
        chk("midrst_no_more_flits", xfer_dat.size() - mark, 2);
        desc_q.delete();
        pay_q.delete();
        exp_q.delete();

        // Random ready and valid toggling over several packets.
        mark = xfer_dat.size();
        rand_rdy = 1'b1;
        rand_vld = 1'b1;
        begin
            int total = 0;
            for (int p = 0; p < 6; p++) begin
                int len = $urandom_range(1, 5);
                queue_pkt(DW'($urandom_range(0, 255)), len, 8'h00, 8'h00, 8'h00, 1'b1);
                total += len + 1;
            end
            wait_drain("random");
            chk("random_count", xfer_dat.size() - mark, total);
        end
        rand_rdy = 1'b0;
        rand_vld = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
